// File: rtl/clock_module_pkg.sv
// rtl/clock_module_pkg.sv - shared clock-tree handshake state type and status decode
package clock_module_pkg;

    typedef enum logic [1:0] {
        CLK_SILENT,
        CLK_STARTING,
        CLK_READY,
        CLK_STOPPING
    } clk_state_t;

    typedef struct packed {
        logic ready;
        logic silent;
        logic starting;
        logic stopping;
    } clk_status_t;

    // One-hot status word seen by the mux parent port for a given state.
    function automatic clk_status_t status_of(input clk_state_t s);
        clk_status_t st;
        st.ready    = (s == CLK_READY);
        st.silent   = (s == CLK_SILENT);
        st.starting = (s == CLK_STARTING);
        st.stopping = (s == CLK_STOPPING);
        return st;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clock_gate_cell.sv
// rtl/clock_gate_cell.sv - latch-based integrated clock gate, swap point for a library ICG
module clock_gate_cell (
    input  logic clock_in,
    input  logic enable,
    input  logic async_resetn,
    output logic clock_out
);

    logic enable_latched;

    // Enable is captured only while the clock is low so the AND below cannot produce runt pulses.
    always_latch begin
        if (!async_resetn) begin
            enable_latched <= 1'b0;
        end else if (!clock_in) begin
            enable_latched <= enable;
        end
    end

    assign clock_out = clock_in & enable_latched;

endmodule

// File: rtl/clock_module_source.sv
// rtl/clock_module_source.sv - root clock source: request filter, start/stop sequencer, output gate
module clock_module_source
    import clock_module_pkg::*;
#(
    parameter int FILTER_CYCLES = 2,
    parameter int START_CYCLES  = 16,
    parameter int STOP_CYCLES   = 4
) (
    input  logic clock,
    input  logic async_resetn,
    input  logic parent_request,
    output logic parent_ready,
    output logic parent_silent,
    output logic parent_starting,
    output logic parent_stopping,
    output logic osc_enable,
    input  logic clock_route_path_in,
    output logic clock_route_path_out
);

    localparam int CNT_W  = $clog2(max_int(START_CYCLES, STOP_CYCLES) + 1);
    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);

    localparam logic [CNT_W-1:0]  START_LAST  = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST   = CNT_W'(STOP_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILTER_LAST = FILT_W'(FILTER_CYCLES - 1);

    logic              req_filt;
    logic [FILT_W-1:0] filt_cnt;

    clk_state_t        state;
    clk_state_t        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    clk_status_t       status_next;
    logic              gate_enable;

    // Request filter: flip only after the raw request disagrees for FILTER_CYCLES edges in a row.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            req_filt <= 1'b0;
            filt_cnt <= '0;
        end else if (parent_request != req_filt) begin
            if (filt_cnt == FILTER_LAST) begin
                req_filt <= parent_request;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    // Sequencer state and settle/drain counter.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state <= CLK_SILENT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: STARTING and STOPPING always run to completion before reacting to the request.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            CLK_SILENT: begin
                if (req_filt) begin
                    state_next = CLK_STARTING;
                    cnt_next   = '0;
                end
            end
            CLK_STARTING: begin
                if (cnt == START_LAST) begin
                    state_next = CLK_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            CLK_READY: begin
                if (!req_filt) begin
                    state_next = CLK_STOPPING;
                    cnt_next   = '0;
                end
            end
            CLK_STOPPING: begin
                if (cnt == STOP_LAST) begin
                    state_next = CLK_SILENT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = CLK_SILENT;
                cnt_next   = '0;
            end
        endcase
        status_next = status_of(state_next);
    end

    // Status, oscillator and gate enables are flopped from the next state so they track the state exactly.
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            parent_ready    <= 1'b0;
            parent_silent   <= 1'b1;
            parent_starting <= 1'b0;
            parent_stopping <= 1'b0;
            osc_enable      <= 1'b0;
            gate_enable     <= 1'b0;
        end else begin
            parent_ready    <= status_next.ready;
            parent_silent   <= status_next.silent;
            parent_starting <= status_next.starting;
            parent_stopping <= status_next.stopping;
            osc_enable      <= (state_next != CLK_SILENT);
            gate_enable     <= (state_next == CLK_READY);
        end
    end

    clock_gate_cell u_gate (
        .clock_in     (clock_route_path_in),
        .enable       (gate_enable),
        .async_resetn (async_resetn),
        .clock_out    (clock_route_path_out)
    );

endmodule
